udp_osd_pkt_parser: RTL and testbench
=====================================

Name: udp_osd_pkt_parser

Overview:
Byte-stream framer that drains the 2048x8 prefetch async FIFO on its read-clock side. It hunts for the OSD command packet sync word and extracts the header (cmd, length). It forwards the payload downstream over a valid/ready stream with a last marker, verifies the trailing checksum, and keeps packet and error statistics. It feeds the OSD overlay command decoder.

Parameters:
MAGIC0, 8'hA5, first sync byte
MAGIC1, 8'h5A, second sync byte
MAX_LEN, 1500, largest legal payload length in bytes
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  single clock (FIFO rd_clk domain)
rst  input  1  reset, synchronous, active-high
fifo_rd_en  output  1  pop strobe to prefetch FIFO
fifo_rd_vld  input  1  FIFO head byte valid (show-ahead)
fifo_rd_data  input  8  FIFO head byte
out_data  output  8  payload byte
out_valid  output  1  payload byte valid
out_ready  input  1  downstream accepts payload byte
out_last  output  1  final payload byte of packet
hdr_cmd  output  8  command byte of current packet
hdr_len  output  16  payload length of current packet
hdr_valid  output  1  one-cycle pulse, header accepted
pkt_done  output  1  one-cycle pulse, packet finished or aborted
pkt_err  output  1  qualifies pkt_done: 1 = checksum or length error
pkt_cnt  output  CNT_W  good packets, saturating
err_cnt  output  CNT_W  bad packets, saturating

Behaviour:
- Reset: clk and rst only. rst is synchronous and active-high. All outputs are 0 and the state is IDLE. rst asserted mid-packet aborts the packet with no pkt_done.
- Byte consumed = cycle with fifo_rd_vld=1 and fifo_rd_en=1.
- fifo_rd_en = fifo_rd_vld and (state!=PAYLOAD or out_ready). The parser never stalls on header bytes.
- Wire format: MAGIC0, MAGIC1, cmd, len_hi, len_lo, len payload bytes, csum.
- csum = 8-bit sum, mod 256, of cmd, len_hi, len_lo and all payload bytes. The running sum clears in IDLE.
- FSM:
  - IDLE: consumed byte == MAGIC0 -> SYNC1. Otherwise stay (bytes discarded).
  - SYNC1: byte == MAGIC1 -> CMD. Byte == MAGIC0 -> stay SYNC1. Else -> IDLE.
  - CMD: latch hdr_cmd -> LEN_H.
  - LEN_H: latch hi byte -> LEN_L.
  - LEN_L: form len.
    - If len > MAX_LEN: pkt_done=1, pkt_err=1, err_cnt++, -> IDLE (resync).
    - Else: hdr_len=len, hdr_valid pulses the cycle after the consume, remaining=len. Go to PAYLOAD if len>0, else CSUM.
  - PAYLOAD: out_valid = fifo_rd_vld and out_data = fifo_rd_data, combinational pass-through with 0-cycle latency.
    - out_last = out_valid and remaining==1.
    - Each handshake (out_valid & out_ready) decrements remaining and adds the byte to the sum.
    - Handshake with remaining==1 -> CSUM.
  - CSUM: compare the consumed byte with the sum, then register pkt_done=1 and pkt_err=(mismatch).
    - Good packet: pkt_cnt++. Bad packet: err_cnt++.
    - -> IDLE.
- Outputs outside PAYLOAD: out_valid=0, out_last=0.
- hdr_cmd and hdr_len hold until the next header is accepted.
- Payload bytes are already forwarded when a checksum error is detected. Downstream discards the packet on pkt_err.
- Counters saturate at all-ones and never wrap.
- FIFO empty (fifo_rd_vld=0) in any state: hold state, no consumption, no output.
- out_ready=0 in PAYLOAD: fifo_rd_en=0 and out_data holds the FIFO head (stable under back-pressure).
- Throughput: 1 byte/cycle when the FIFO is non-empty and out_ready=1. Back-to-back packets need no idle gap; the next MAGIC0 is consumed in the cycle after CSUM.

Test Plan:
- Good packet, full rate: A5 5A 03 00 04 11 22 33 44 CSUM=(03+00+04+11+22+33+44)&FF=B1.
  - Response: hdr_valid with cmd=03, len=4.
  - out_data 11,22,33,44 on 4 consecutive cycles, out_last on 44.
  - pkt_done=1, pkt_err=0, pkt_cnt=1.
- Same packet with csum=B0 -> all 4 payload bytes forwarded, then pkt_done=1, pkt_err=1, err_cnt=1, pkt_cnt unchanged.
- Garbage then sync: 00 A5 A5 5A 07 00 00 07 -> zero-length packet.
  - Response: hdr_valid with len=0, no out_valid, pkt_done=1, pkt_err=0.
- Length 0x05DD (1501) > MAX_LEN -> pkt_done=1, pkt_err=1, err_cnt=1, no hdr_valid. A following valid packet parses correctly.
- Back-pressure: toggle out_ready 1/0 every cycle and insert FIFO empty gaps during a 16-byte payload.
  - Response: all 16 bytes delivered in order, no duplicates, fifo_rd_en never high while out_ready=0 in PAYLOAD.
- rst asserted at payload byte 2 of 4 -> next cycle all outputs 0 and state IDLE, no pkt_done. The following packet parses with pkt_cnt counting from 0.

Source files
------------

// File: rtl/udp_osd_pkt_parser.sv
// Purpose: OSD command packet framer on the prefetch FIFO read side. It hunts for the sync word, extracts the header, forwards the payload and checks the checksum.
// Latency: payload is a 0-cycle pass-through; hdr_valid, pkt_done and the counters update one cycle after the consuming byte.
// Backpressure: out_ready=0 in PAYLOAD stops the FIFO pops. Header, sync and checksum bytes are consumed whenever the FIFO is non-empty.
module udp_osd_pkt_parser #(
    parameter logic [7:0] MAGIC0  = 8'hA5,
    parameter logic [7:0] MAGIC1  = 8'h5A,
    parameter int         MAX_LEN = 1500,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_vld,
    input  logic [7:0]       fifo_rd_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [7:0]       hdr_cmd,
    output logic [15:0]      hdr_len,
    output logic             hdr_valid,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC1   = 3'd1;
    localparam logic [2:0] ST_CMD     = 3'd2;
    localparam logic [2:0] ST_LEN_H   = 3'd3;
    localparam logic [2:0] ST_LEN_L   = 3'd4;
    localparam logic [2:0] ST_PAYLOAD = 3'd5;
    localparam logic [2:0] ST_CSUM    = 3'd6;

    localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [7:0]  cmd_q;
    logic [7:0]  len_hi_q;
    logic [7:0]  sum_q;
    logic [15:0] remaining_q;

    logic        in_payload;
    logic        consume;
    logic [15:0] len_w;
    logic        len_bad;
    logic        csum_bad;

    assign in_payload = (state == ST_PAYLOAD);
    assign consume    = fifo_rd_vld & fifo_rd_en;
    assign len_w      = {len_hi_q, fifo_rd_data};
    assign len_bad    = (len_w > MAX_LEN_W);
    assign csum_bad   = (fifo_rd_data != sum_q);

    // FIFO pop and payload pass-through; everything is forced low while in reset
    always_comb begin
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        if (!rst) begin
            fifo_rd_en = fifo_rd_vld & (~in_payload | out_ready);
            if (in_payload) begin
                out_valid = fifo_rd_vld;
                out_data  = fifo_rd_data;
                out_last  = fifo_rd_vld & (remaining_q == 16'd1);
            end
        end
    end

    // Next-state logic: the FSM only advances on a consumed byte
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (consume && fifo_rd_data == MAGIC0)
                    state_nxt = ST_SYNC1;
            end
            ST_SYNC1: begin
                // A repeated MAGIC0 may still be the start of a real sync word
                if (consume) begin
                    if (fifo_rd_data == MAGIC1)
                        state_nxt = ST_CMD;
                    else if (fifo_rd_data != MAGIC0)
                        state_nxt = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (consume)
                    state_nxt = ST_LEN_H;
            end
            ST_LEN_H: begin
                if (consume)
                    state_nxt = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (consume) begin
                    if (len_bad)
                        state_nxt = ST_IDLE;
                    else if (len_w == 16'd0)
                        state_nxt = ST_CSUM;
                    else
                        state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // In PAYLOAD a consume is exactly a downstream handshake
                if (consume && remaining_q == 16'd1)
                    state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (consume)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Header capture, running checksum and payload byte countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= 8'h00;
            len_hi_q    <= 8'h00;
            sum_q       <= 8'h00;
            remaining_q <= 16'd0;
            hdr_cmd     <= 8'h00;
            hdr_len     <= 16'd0;
        end else begin
            if (state == ST_IDLE)
                sum_q <= 8'h00;
            if (consume) begin
                case (state)
                    ST_CMD: begin
                        cmd_q <= fifo_rd_data;
                        sum_q <= sum_q + fifo_rd_data;
                    end
                    ST_LEN_H: begin
                        len_hi_q <= fifo_rd_data;
                        sum_q    <= sum_q + fifo_rd_data;
                    end
                    ST_LEN_L: begin
                        // The visible header only changes once a length is accepted
                        if (!len_bad) begin
                            sum_q       <= sum_q + fifo_rd_data;
                            hdr_cmd     <= cmd_q;
                            hdr_len     <= len_w;
                            remaining_q <= len_w;
                        end
                    end
                    ST_PAYLOAD: begin
                        sum_q       <= sum_q + fifo_rd_data;
                        remaining_q <= remaining_q - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // One-cycle status pulses: header accepted, packet finished or aborted
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            if (consume && state == ST_LEN_L) begin
                if (len_bad) begin
                    pkt_done <= 1'b1;
                    pkt_err  <= 1'b1;
                end else begin
                    hdr_valid <= 1'b1;
                end
            end
            if (consume && state == ST_CSUM) begin
                pkt_done <= 1'b1;
                pkt_err  <= csum_bad;
            end
        end
    end

    // Saturating good/bad packet counters, updated alongside pkt_done
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (consume) begin
            if ((state == ST_LEN_L && len_bad) || (state == ST_CSUM && csum_bad)) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + CNT_ONE;
            end else if (state == ST_CSUM) begin
                if (pkt_cnt != '1)
                    pkt_cnt <= pkt_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_udp_osd_pkt_parser.sv
// Purpose: randomized and directed stimulus for udp_osd_pkt_parser, checked against a byte-stream parse model.
// Latency: each segment runs until its byte stream has drained, plus a few idle cycles.
// Backpressure: the bench drives FIFO empty gaps and out_ready stalls.
module tb_udp_osd_pkt_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_en;
    logic        fifo_rd_vld;
    logic [7:0]  fifo_rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [7:0]  hdr_cmd;
    logic [15:0] hdr_len;
    logic        hdr_valid;
    logic        pkt_done;
    logic        pkt_err;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    udp_osd_pkt_parser dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .hdr_cmd      (hdr_cmd),
        .hdr_len      (hdr_len),
        .hdr_valid    (hdr_valid),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err),
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stim[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_pay[$];
    logic        exp_last[$];
    logic [23:0] exp_hdr[$];
    logic        exp_err[$];
    logic [31:0] exp_cnt[$];
    logic [7:0]  obs_pay[$];
    logic        obs_last[$];
    logic [23:0] obs_hdr[$];
    logic        obs_err[$];
    logic [31:0] obs_cnt[$];
    int          m_pc = 0;
    int          m_ec = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet builder: optional corrupted checksum
    task automatic add_pkt(input logic [7:0] cmd, input int len, input bit bad);
        logic [7:0] s;
        logic [7:0] b;
        stim.push_back(8'hA5);
        stim.push_back(8'h5A);
        stim.push_back(cmd);
        stim.push_back(8'(len >> 8));
        stim.push_back(8'(len));
        s = 8'(cmd + 8'(len >> 8) + 8'(len));
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            stim.push_back(b);
            s = 8'(s + b);
        end
        stim.push_back(bad ? 8'(s ^ 8'h01) : s);
    endtask

    task automatic add_garbage(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (b == 8'hA5)
                b = 8'h00;
            stim.push_back(b);
        end
    endtask

    // Reference: walk the whole byte list and list what should come out
    task automatic model_parse();
        int i = 0;
        int j;
        int n = stim.size();
        int len;
        logic [7:0] s;
        while (i < n) begin
            if (stim[i] != 8'hA5) begin
                i++;
                continue;
            end
            j = i + 1;
            while (j < n && stim[j] == 8'hA5)
                j++;
            if (j >= n)
                break;
            if (stim[j] != 8'h5A) begin
                i = j + 1;
                continue;
            end
            if (j + 3 >= n)
                break;
            len = int'({stim[j+2], stim[j+3]});
            if (len > 1500) begin
                if (m_ec < 65535)
                    m_ec++;
                exp_err.push_back(1'b1);
                exp_cnt.push_back({16'(m_pc), 16'(m_ec)});
                i = j + 4;
                continue;
            end
            if (j + 4 + len >= n)
                break;
            exp_hdr.push_back({stim[j+1], 16'(len)});
            s = 8'(stim[j+1] + stim[j+2] + stim[j+3]);
            for (int k = 0; k < len; k++) begin
                s = 8'(s + stim[j+4+k]);
                exp_pay.push_back(stim[j+4+k]);
                exp_last.push_back(k == len - 1);
            end
            if (stim[j+4+len] != s) begin
                if (m_ec < 65535)
                    m_ec++;
                exp_err.push_back(1'b1);
            end else begin
                if (m_pc < 65535)
                    m_pc++;
                exp_err.push_back(1'b0);
            end
            exp_cnt.push_back({16'(m_pc), 16'(m_ec)});
            i = j + 5 + len;
        end
    endtask

    // mode 0: full rate, 1: random gaps and ready, 2: gaps with ready toggling every cycle
    task automatic run_seg(input int mode, input int stop_after);
        int consumed_n = 0;
        int idle = 0;
        int cyc = 0;
        bit cons;
        tx_q = stim;
        while (idle < 4 && cyc < 20000 && (stop_after < 0 || consumed_n < stop_after)) begin
            if (tx_q.size() > 0 && (mode == 0 || $urandom_range(3) != 0)) begin
                fifo_rd_vld  = 1'b1;
                fifo_rd_data = tx_q[0];
            end else begin
                fifo_rd_vld  = 1'b0;
                fifo_rd_data = 8'($urandom);
            end
            if (mode == 0)
                out_ready = 1'b1;
            else if (mode == 2)
                out_ready = ~out_ready;
            else
                out_ready = 1'($urandom_range(1));
            @(negedge clk);
            chk("rd_en", 32'(fifo_rd_en), 32'(fifo_rd_vld && !(out_valid && !out_ready)));
            if (out_valid)
                chk("pass_data", 32'(out_data), 32'(fifo_rd_data));
            else
                chk("last_idle", 32'(out_last), 32'd0);
            if (out_valid && out_ready) begin
                obs_pay.push_back(out_data);
                obs_last.push_back(out_last);
            end
            if (hdr_valid)
                obs_hdr.push_back({hdr_cmd, hdr_len});
            if (pkt_done) begin
                obs_err.push_back(pkt_err);
                obs_cnt.push_back({pkt_cnt, err_cnt});
            end
            cons = fifo_rd_vld && fifo_rd_en;
            @(posedge clk);
            #1;
            cyc++;
            if (cons) begin
                void'(tx_q.pop_front());
                consumed_n++;
                idle = 0;
            end else if (tx_q.size() == 0) begin
                idle++;
            end
        end
        if (stop_after < 0)
            chk("timeout", 32'(tx_q.size()), 32'd0);
        fifo_rd_vld = 1'b0;
    endtask

    task automatic clear_seg();
        stim.delete();
        tx_q.delete();
        exp_pay.delete();  exp_last.delete(); exp_hdr.delete(); exp_err.delete(); exp_cnt.delete();
        obs_pay.delete();  obs_last.delete(); obs_hdr.delete(); obs_err.delete(); obs_cnt.delete();
    endtask

    task automatic compare_seg();
        chk("n_pay", 32'(obs_pay.size()), 32'(exp_pay.size()));
        for (int k = 0; k < obs_pay.size() && k < exp_pay.size(); k++) begin
            chk("pay", 32'(obs_pay[k]), 32'(exp_pay[k]));
            chk("last", 32'(obs_last[k]), 32'(exp_last[k]));
        end
        chk("n_hdr", 32'(obs_hdr.size()), 32'(exp_hdr.size()));
        for (int k = 0; k < obs_hdr.size() && k < exp_hdr.size(); k++)
            chk("hdr", 32'(obs_hdr[k]), 32'(exp_hdr[k]));
        chk("n_done", 32'(obs_err.size()), 32'(exp_err.size()));
        for (int k = 0; k < obs_err.size() && k < exp_err.size(); k++) begin
            chk("pkt_err", 32'(obs_err[k]), 32'(exp_err[k]));
            chk("cnts", obs_cnt[k], exp_cnt[k]);
        end
        clear_seg();
    endtask

    task automatic seg(input int mode);
        model_parse();
        run_seg(mode, -1);
        compare_seg();
    endtask

    initial begin
        rst          = 1'b1;
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = 8'h00;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_hdr", {8'h00, hdr_cmd, hdr_len}, 32'd0);
        chk("rst_cnts", {pkt_cnt, err_cnt}, 32'd0);
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 8'hA5;
        @(negedge clk);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        fifo_rd_vld = 1'b0;

        // Reference packet, full rate: expected csum B1
        stim = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB1};
        seg(0);
        // Same packet with a bad checksum
        stim = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hB0};
        seg(0);
        // Garbage, repeated MAGIC0, zero-length packet
        stim = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h07, 8'h00, 8'h00, 8'h07};
        seg(0);
        // Oversized length followed by a good packet
        stim = '{8'hA5, 8'h5A, 8'h01, 8'h05, 8'hDD};
        add_pkt(8'h02, 3, 1'b0);
        seg(0);
        // Largest legal payload, under random back-pressure
        add_pkt(8'h44, 1500, 1'b0);
        seg(1);
        // 16-byte payload, ready toggling every cycle plus FIFO gaps
        add_pkt(8'h16, 16, 1'b0);
        seg(2);

        // Reset in the middle of a payload: no pkt_done, counters cleared
        stim = '{8'hA5, 8'h5A, 8'h09, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        run_seg(0, 6);
        rst          = 1'b1;
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 8'hBB;
        @(posedge clk);
        #1;
        chk("mid_rst_outs", {fifo_rd_en, out_valid, out_last, hdr_valid, pkt_done, pkt_err, 26'd0}, 32'd0);
        chk("mid_rst_cnts", {pkt_cnt, err_cnt}, 32'd0);
        chk("mid_rst_hdr", {8'h00, hdr_cmd, hdr_len}, 32'd0);
        chk("mid_rst_seen_hdr", 32'(obs_hdr.size()), 32'd1);
        chk("mid_rst_seen_pay", 32'(obs_pay.size()), 32'd1);
        chk("mid_rst_no_done", 32'(obs_err.size()), 32'd0);
        rst         = 1'b0;
        fifo_rd_vld = 1'b0;
        clear_seg();
        m_pc = 0;
        m_ec = 0;
        add_pkt(8'h21, 4, 1'b0);
        seg(0);

        // Random traffic: garbage, good/bad/oversized packets, random back-pressure
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 6; p++) begin
                add_garbage($urandom_range(3));
                if ($urandom_range(7) == 0) begin
                    stim.push_back(8'hA5);
                    stim.push_back(8'h5A);
                    stim.push_back(8'($urandom));
                    stim.push_back(8'($urandom_range(255, 6)));
                    stim.push_back(8'($urandom));
                end else begin
                    add_pkt(8'($urandom), $urandom_range(20), $urandom_range(4) == 0);
                end
            end
            seg(r % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
